// File: rtl/dpram_latency_sched_if.sv
// Per-port request/response and RAM-side bundle for dpram_latency_sched.
// master: requester plus RAM read data; slave: the scheduler.
interface dpram_latency_sched_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  req;
    logic                  ready;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output req, wr, addr, wdata, mem_rdata,
        input  ready, rd_valid, rd_data, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, wr, addr, wdata, mem_rdata,
        output ready, rd_valid, rd_data, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dpram_latency_sched.sv
// Dual-port RAM request scheduler: fixed write/read latencies, per-port credits, A-wins arbitration.
// Optional registered collision flag enabled by defining DPRAM_SCHED_COLLISION_EN.
module dpram_latency_sched #(
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH    = 16,
    parameter int unsigned ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int unsigned WR_LATENCYA  = 10,
    parameter int unsigned RD_LATENCYA  = 5,
    parameter int unsigned WR_LATENCYB  = 7,
    parameter int unsigned RD_LATENCYB  = 8,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    dpram_latency_sched_if.slave   a,
    dpram_latency_sched_if.slave   b,
    output logic                   collision
);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    // Port A pipelines and credit counter
    logic [WR_LATENCYA-1:0] aw_v_q;
    logic [ADDR_WIDTH-1:0]  aw_addr_q [WR_LATENCYA];
    logic [DATA_WIDTH-1:0]  aw_data_q [WR_LATENCYA];
    logic [RD_LATENCYA-1:0] ar_v_q;
    logic [DATA_WIDTH-1:0]  ar_data_q [RD_LATENCYA];
    logic [CNT_W-1:0]       a_cnt_q, a_cnt_d;
    logic                   a_due, a_commit, a_ready, a_acc;

    // Port B pipelines and credit counter
    logic [WR_LATENCYB-1:0] bw_v_q;
    logic [ADDR_WIDTH-1:0]  bw_addr_q [WR_LATENCYB];
    logic [DATA_WIDTH-1:0]  bw_data_q [WR_LATENCYB];
    logic [RD_LATENCYB-1:0] br_v_q;
    logic [DATA_WIDTH-1:0]  br_data_q [RD_LATENCYB];
    logic [CNT_W-1:0]       b_cnt_q, b_cnt_d;
    logic                   b_due, b_commit, b_ready, b_acc;
    logic                   same_commit_addr;

    // A read must not be accepted while a write commit is due on the next cycle
    if (WR_LATENCYA > 1) begin : g_a_due
        assign a_due = aw_v_q[WR_LATENCYA-2];
    end else begin : g_a_due_none
        assign a_due = 1'b0;
    end

    if (WR_LATENCYB > 1) begin : g_b_due
        assign b_due = bw_v_q[WR_LATENCYB-2];
    end else begin : g_b_due_none
        assign b_due = 1'b0;
    end

    always_comb begin
        a_commit = aw_v_q[WR_LATENCYA-1] & ~rst;
        b_commit = bw_v_q[WR_LATENCYB-1] & ~rst;
        same_commit_addr = aw_addr_q[WR_LATENCYA-1] == bw_addr_q[WR_LATENCYB-1];

        a_ready = ~rst & (a_cnt_q < CNT_MAX) & ~(a_due & ~a.wr);
        b_ready = ~rst & (b_cnt_q < CNT_MAX) & ~(b_due & ~b.wr);
        a_acc   = a.req & a_ready;
        b_acc   = b.req & b_ready;
        a.ready = a_ready;
        b.ready = b_ready;

        a.mem_we    = a_commit;
        a.mem_addr  = rst ? '0 : (a_commit ? aw_addr_q[WR_LATENCYA-1] : a.addr);
        a.mem_wdata = rst ? '0 : aw_data_q[WR_LATENCYA-1];
        a.rd_valid  = ar_v_q[RD_LATENCYA-1] & ~rst;
        a.rd_data   = rst ? '0 : ar_data_q[RD_LATENCYA-1];

        // Port A wins a same-address commit; B still retires its credit
        b.mem_we    = b_commit & ~(a_commit & same_commit_addr);
        b.mem_addr  = rst ? '0 : (b_commit ? bw_addr_q[WR_LATENCYB-1] : b.addr);
        b.mem_wdata = rst ? '0 : bw_data_q[WR_LATENCYB-1];
        b.rd_valid  = br_v_q[RD_LATENCYB-1] & ~rst;
        b.rd_data   = rst ? '0 : br_data_q[RD_LATENCYB-1];

        a_cnt_d = CNT_W'(int'(a_cnt_q) + int'(a_acc) - int'(a_commit) - int'(a.rd_valid));
        b_cnt_d = CNT_W'(int'(b_cnt_q) + int'(b_acc) - int'(b_commit) - int'(b.rd_valid));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_v_q  <= '0;
            ar_v_q  <= '0;
            a_cnt_q <= '0;
            for (int unsigned i = 0; i < WR_LATENCYA; i++) begin
                aw_addr_q[i] <= '0;
                aw_data_q[i] <= '0;
            end
            for (int unsigned i = 0; i < RD_LATENCYA; i++) ar_data_q[i] <= '0;
        end else begin
            aw_v_q[0]    <= a_acc & a.wr;
            aw_addr_q[0] <= a.addr;
            aw_data_q[0] <= a.wdata;
            for (int unsigned i = 1; i < WR_LATENCYA; i++) begin
                aw_v_q[i]    <= aw_v_q[i-1];
                aw_addr_q[i] <= aw_addr_q[i-1];
                aw_data_q[i] <= aw_data_q[i-1];
            end
            ar_v_q[0]    <= a_acc & ~a.wr;
            ar_data_q[0] <= a.mem_rdata;
            for (int unsigned i = 1; i < RD_LATENCYA; i++) begin
                ar_v_q[i]    <= ar_v_q[i-1];
                ar_data_q[i] <= ar_data_q[i-1];
            end
            a_cnt_q <= a_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bw_v_q  <= '0;
            br_v_q  <= '0;
            b_cnt_q <= '0;
            for (int unsigned i = 0; i < WR_LATENCYB; i++) begin
                bw_addr_q[i] <= '0;
                bw_data_q[i] <= '0;
            end
            for (int unsigned i = 0; i < RD_LATENCYB; i++) br_data_q[i] <= '0;
        end else begin
            bw_v_q[0]    <= b_acc & b.wr;
            bw_addr_q[0] <= b.addr;
            bw_data_q[0] <= b.wdata;
            for (int unsigned i = 1; i < WR_LATENCYB; i++) begin
                bw_v_q[i]    <= bw_v_q[i-1];
                bw_addr_q[i] <= bw_addr_q[i-1];
                bw_data_q[i] <= bw_data_q[i-1];
            end
            br_v_q[0]    <= b_acc & ~b.wr;
            br_data_q[0] <= b.mem_rdata;
            for (int unsigned i = 1; i < RD_LATENCYB; i++) begin
                br_v_q[i]    <= br_v_q[i-1];
                br_data_q[i] <= br_data_q[i-1];
            end
            b_cnt_q <= b_cnt_d;
        end
    end

`ifdef DPRAM_SCHED_COLLISION_EN
    logic coll_d, coll_q;

    // Write/write on the same address, or a write racing the other port's read sample
    always_comb begin
        coll_d = (a_commit & b_commit & same_commit_addr)
               | (a_commit & b_acc & ~b.wr & (a.mem_addr == b.mem_addr))
               | (b_commit & a_acc & ~a.wr & (b.mem_addr == a.mem_addr));
    end

    always_ff @(posedge clk) begin
        if (rst) coll_q <= 1'b0;
        else     coll_q <= coll_d;
    end

    assign collision = coll_q;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_latency_sched.sv
// Randomized bench for dpram_latency_sched against a due-cycle transaction model.
module tb_dpram_latency_sched;
    localparam int WRA = 10, RDA = 5, WRB = 7, RDB = 8, MAXI = 4;

    typedef struct {
        int         due;
        int         port;
        bit         wr;
        logic [3:0] addr;
        logic [3:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic collision;
    always #5 clk = ~clk;

    dpram_latency_sched_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) ia ();
    dpram_latency_sched_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) ib ();

    dpram_latency_sched #(
        .DATA_WIDTH(4), .MEM_DEPTH(16), .ADDR_WIDTH(4),
        .WR_LATENCYA(WRA), .RD_LATENCYA(RDA), .WR_LATENCYB(WRB), .RD_LATENCYB(RDB),
        .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a(ia),
        .b(ib),
        .collision(collision)
    );

    logic [3:0] ram [16] = '{default: 4'h0};
    always @(posedge clk) begin
        if (ib.mem_we) ram[ib.mem_addr] <= ib.mem_wdata;
        if (ia.mem_we) ram[ia.mem_addr] <= ia.mem_wdata;
    end
    assign ia.mem_rdata = ram[ia.mem_addr];
    assign ib.mem_rdata = ram[ib.mem_addr];

    txn_t       pend[$];
    logic [3:0] mref [16];
    bit         coll_prev;
    int         cyc, checks, errors;
    int         wrl[2] = '{WRA, WRB};
    int         rdl[2] = '{RDA, RDB};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rs, input bit areq, input bit awr, input logic [3:0] aa,
                        input logic [3:0] ad, input bit breq, input bit bwr,
                        input logic [3:0] ba, input logic [3:0] bd);
        bit         req[2], wr[2], cm[2], rv[2], dn[2], acc[2], rdy[2], same, cnext;
        logic [3:0] adr[2], wd[2], caddr[2], cdata[2], rdat[2], used[2];
        int         outst[2];
        txn_t       t;
        txn_t       keep[$];
        rst = rs;
        ia.req = areq; ia.wr = awr; ia.addr = aa; ia.wdata = ad;
        ib.req = breq; ib.wr = bwr; ib.addr = ba; ib.wdata = bd;
        req = '{areq, breq}; wr = '{awr, bwr}; adr = '{aa, ba}; wd = '{ad, bd};
        #1;
        if (rs) begin
            check("a_ready_rst", ia.ready, 0);
            check("b_ready_rst", ib.ready, 0);
            check("a_we_rst", ia.mem_we, 0);
            check("b_we_rst", ib.mem_we, 0);
            check("a_rdv_rst", ia.rd_valid, 0);
            check("b_rdv_rst", ib.rd_valid, 0);
            pend.delete();
            coll_prev = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                cm[p] = 0; rv[p] = 0; dn[p] = 0; outst[p] = 0;
                caddr[p] = 0; cdata[p] = 0; rdat[p] = 0;
            end
            foreach (pend[i]) begin
                t = pend[i];
                outst[t.port]++;
                if (t.wr && t.due == cyc) begin
                    cm[t.port] = 1; caddr[t.port] = t.addr; cdata[t.port] = t.data;
                end
                if (t.wr && t.due == cyc + 1) dn[t.port] = 1;
                if (!t.wr && t.due == cyc) begin
                    rv[t.port] = 1; rdat[t.port] = t.data;
                end
            end
            for (int p = 0; p < 2; p++) begin
                rdy[p]  = outst[p] < MAXI && !(dn[p] && !wr[p]);
                acc[p]  = req[p] && rdy[p];
                used[p] = cm[p] ? caddr[p] : adr[p];
            end
            same = cm[0] && cm[1] && caddr[0] == caddr[1];
            check("a_ready", ia.ready, rdy[0]);
            check("b_ready", ib.ready, rdy[1]);
            check("a_we", ia.mem_we, cm[0]);
            check("b_we", ib.mem_we, cm[1] && !same);
            check("a_mem_addr", ia.mem_addr, used[0]);
            check("b_mem_addr", ib.mem_addr, used[1]);
            if (cm[0]) check("a_mem_wdata", ia.mem_wdata, cdata[0]);
            if (cm[1]) check("b_mem_wdata", ib.mem_wdata, cdata[1]);
            check("a_rd_valid", ia.rd_valid, rv[0]);
            check("b_rd_valid", ib.rd_valid, rv[1]);
            if (rv[0]) check("a_rd_data", ia.rd_data, rdat[0]);
            if (rv[1]) check("b_rd_data", ib.rd_data, rdat[1]);
`ifdef DPRAM_SCHED_COLLISION_EN
            check("collision", collision, coll_prev);
`else
            check("collision", collision, 0);
`endif
            cnext = same || (cm[0] && acc[1] && !wr[1] && used[0] == used[1])
                         || (cm[1] && acc[0] && !wr[0] && used[1] == used[0]);
            coll_prev = cnext;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    t.port = p;
                    t.wr   = wr[p];
                    t.addr = adr[p];
                    t.due  = cyc + (wr[p] ? wrl[p] : rdl[p]);
                    t.data = wr[p] ? wd[p] : mref[used[p]];
                    pend.push_back(t);
                end
            end
            if (cm[1] && !same) mref[caddr[1]] = cdata[1];
            if (cm[0]) mref[caddr[0]] = cdata[0];
            foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
            pend = keep;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
    endtask

    function automatic logic [3:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        checks = 0; errors = 0; cyc = 0; coll_prev = 0;
        for (int i = 0; i < 16; i++) mref[i] = 4'h0;
        rst = 1'b1;
        ia.req = 0; ia.wr = 0; ia.addr = 0; ia.wdata = 0;
        ib.req = 0; ib.wr = 0; ib.addr = 0; ib.wdata = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
        step(1, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
        check("a_rd_data_rst", ia.rd_data, 0);
        check("b_rd_data_rst", ib.rd_data, 0);
        check("a_wdata_rst", ia.mem_wdata, 0);
        check("b_wdata_rst", ib.mem_wdata, 0);
        check("collision_rst", collision, 0);

        // A write 3/0xA, then B read 3 eleven cycles later
        step(0, 1, 1, 4'h3, 4'hA, 0, 0, 4'h0, 4'h0);
        idle(10);
        step(0, 0, 0, 4'h0, 4'h0, 1, 0, 4'h3, 4'h0);
        idle(10);
        check("ram3", ram[3], 4'hA);

        // Credit exhaustion with five back-to-back A writes
        for (int i = 0; i < 5; i++) step(0, 1, 1, 4'(8 + i), 4'(i + 1), 0, 0, 4'h0, 4'h0);
        idle(15);

        // Same-address write collision: A wins
        step(0, 1, 1, 4'h5, 4'h1, 0, 0, 4'h0, 4'h0);
        idle(2);
        step(0, 0, 0, 4'h0, 4'h0, 1, 1, 4'h5, 4'h2);
        idle(8);
        check("ram5", ram[5], 4'h1);
        idle(5);

        // Reset flushes a pending write
        step(0, 1, 1, 4'h6, 4'h9, 0, 0, 4'h0, 4'h0);
        idle(3);
        step(1, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
        idle(10);
        check("ram6", ram[6], 4'h0);

        // Read stalled the cycle before a pending A commit
        step(0, 1, 1, 4'h7, 4'hC, 0, 0, 4'h0, 4'h0);
        idle(8);
        step(0, 1, 0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0);
        step(0, 1, 0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0);
        idle(10);

        repeat (3000) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rnd_addr(),
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rnd_addr(),
                 4'($urandom_range(0, 15)));
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
